// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS pipeline.
// Fetches over a req/ack instruction memory and honours the hazard stall and EX redirects.
module pipe_if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
  } ifid_t;

  state_t      state, state_nx;
  ifid_t       ifid, ifid_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] tgt, tgt_nx;
  logic        tgt_v, tgt_v_nx;
  logic [31:0] hbuf, hbuf_nx;
  logic [31:0] pc4, sel_tgt, npc;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    sel_tgt = pc4;
    case (pcsource)
      2'b00: sel_tgt = pc4;
      2'b01: sel_tgt = bpc;
      2'b10: sel_tgt = rpc;
      2'b11: sel_tgt = jpc;
      default: sel_tgt = pc4;
    endcase
  end

  // A latched redirect outranks decode's select: the jump has already left decode.
  assign npc = tgt_v ? tgt : sel_tgt;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ: begin
        if (flush)                    state_nx = imem_ack ? S_REQ : S_DRAIN;
        else if (imem_ack && !wpcir)  state_nx = S_HOLD;
      end
      S_HOLD:  if (flush || wpcir) state_nx = S_REQ;
      S_DRAIN: if (imem_ack)       state_nx = S_REQ;
      default: state_nx = S_REQ;
    endcase
  end

  // output logic
  always_comb begin
    imem_req  = (state != S_HOLD);
    imem_addr = pc_q;
  end

  // datapath next values
  always_comb begin
    ifid_nx  = ifid;
    pc_nx    = pc_q;
    tgt_nx   = tgt;
    tgt_v_nx = tgt_v;
    hbuf_nx  = hbuf;
    case (state)
      S_REQ: begin
        if (flush) begin
          ifid_nx.inst = NOP_INST;
          ifid_nx.v    = 1'b0;
          if (imem_ack) begin
            pc_nx    = flush_pc;
            tgt_v_nx = 1'b0;
          end else begin
            tgt_nx   = flush_pc;
            tgt_v_nx = 1'b1;
          end
        end else if (imem_ack) begin
          if (wpcir) begin
            ifid_nx  = '{inst: imem_rdata, pc4: pc4, v: 1'b1};
            pc_nx    = npc;
            tgt_v_nx = 1'b0;
          end else begin
            hbuf_nx  = imem_rdata;
          end
        end else if (wpcir) begin
          ifid_nx.inst = NOP_INST;
          ifid_nx.v    = 1'b0;
          // Jump leaving decode while its delay slot is still in flight.
          if (ifid.v && pcsource != 2'b00) begin
            tgt_nx   = sel_tgt;
            tgt_v_nx = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          ifid_nx.inst = NOP_INST;
          ifid_nx.v    = 1'b0;
          pc_nx        = flush_pc;
          tgt_v_nx     = 1'b0;
        end else if (wpcir) begin
          ifid_nx  = '{inst: hbuf, pc4: pc4, v: 1'b1};
          pc_nx    = npc;
          tgt_v_nx = 1'b0;
        end
      end
      S_DRAIN: begin
        ifid_nx.inst = NOP_INST;
        ifid_nx.v    = 1'b0;
        if (flush) tgt_nx = flush_pc;
        if (imem_ack) begin
          pc_nx    = flush ? flush_pc : tgt;
          tgt_v_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      ifid  <= '{inst: NOP_INST, pc4: 32'd0, v: 1'b0};
      tgt   <= 32'd0;
      tgt_v <= 1'b0;
      hbuf  <= 32'd0;
    end else begin
      pc_q  <= pc_nx;
      ifid  <= ifid_nx;
      tgt   <= tgt_nx;
      tgt_v <= tgt_v_nx;
      hbuf  <= hbuf_nx;
    end
  end

  assign pc     = pc_q;
  assign dinst  = ifid.inst;
  assign dpc4   = ifid.pc4;
  assign dvalid = ifid.v;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: latency-programmable memory model plus an
// address scoreboard checked whenever IF/ID is freshly loaded.
module tb_pipe_if_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wpcir = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, rpc = '0, jpc = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, dpc4, dinst;
  logic        dvalid;

  int ntot = 0, npass = 0, nfail = 0;
  int lat = 0;
  int cnt;
  logic [31:0] sb[$];

  pipe_if_stage dut (
    .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ {16'h0, a[31:16]};
  endfunction

  // memory: ack after `lat` waiting cycles of a held request
  always @(posedge clock or posedge reset) begin
    if (reset)                      cnt <= 0;
    else if (imem_req && imem_ack)  cnt <= 0;
    else if (imem_req)              cnt <= cnt + 1;
  end
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = word_at(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; with wpcir high, a valid IF/ID afterwards is a fresh delivery.
  task automatic step();
    logic        w;
    logic [31:0] a;
    w = wpcir;
    @(posedge clock); #1;
    if (w && dvalid) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        a = sb.pop_front();
        chk("dinst", dinst, word_at(a));
        chk("dpc4", dpc4, a + 32'd4);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_dinst", dinst, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    do_reset();
    chk("req_after_rst", 32'(imem_req), 32'd1);

    // zero-wait streaming
    lat = 0;
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_pc", pc, 32'((i + 1) * 4));
    end

    // three wait states per fetch
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(32'h10 + 32'(k * 4));
      for (int j = 0; j < 3; j++) begin
        step();
        chk("wait_dvalid", 32'(dvalid), 32'd0);
        chk("wait_dinst", dinst, 32'h0);
        chk("wait_addr", imem_addr, 32'h10 + 32'(k * 4));
      end
      step();
      chk("wait_pc", pc, 32'h14 + 32'(k * 4));
    end

    // stall with buffered word
    do_reset();
    lat = 0;
    sb.push_back(32'h0); sb.push_back(32'h4);
    step(); step();
    chk("stall_pre_pc", pc, 32'h8);
    wpcir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_dinst", dinst, word_at(32'h4));
      chk("hold_pc", pc, 32'h8);
    end
    wpcir = 1'b1;
    sb.push_back(32'h8);
    step();
    chk("release_pc", pc, 32'hC);
    chk("release_req", 32'(imem_req), 32'd1);

    // jump in decode, delay slot fetched slowly
    sb.push_back(32'hC);
    step();
    chk("j_in_ifid_pc", pc, 32'h10);
    lat = 2; pcsource = 2'b11; jpc = 32'h100;
    sb.push_back(32'h10);
    step();
    chk("j_bubble", 32'(dvalid), 32'd0);
    pcsource = 2'b00; jpc = 32'h0;
    step();
    chk("j_addr_held", imem_addr, 32'h10);
    step();
    chk("j_target_pc", pc, 32'h100);
    lat = 0;
    sb.push_back(32'h100);
    step();
    chk("j_next_pc", pc, 32'h104);

    // flush with same-cycle ack, then flush during a slow fetch
    flush = 1'b1; flush_pc = 32'h20;
    step();
    chk("flush_ack_pc", pc, 32'h20);
    chk("flush_ack_dvalid", 32'(dvalid), 32'd0);
    lat = 2; flush_pc = 32'h40;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_addr", imem_addr, 32'h20);
      chk("drain_dvalid", 32'(dvalid), 32'd0);
      step();
    end
    chk("drain_done_dvalid", 32'(dvalid), 32'd0);
    chk("drain_done_addr", imem_addr, 32'h40);
    lat = 0;
    sb.push_back(32'h40);
    step();
    chk("post_flush_pc", pc, 32'h44);

    // asynchronous reset during S_HOLD
    wpcir = 1'b0;
    step();
    chk("pre_rst_hold_req", 32'(imem_req), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_dvalid", 32'(dvalid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd1);
    @(posedge clock); #1 reset = 1'b0;
    wpcir = 1'b1;

    // wrap at the top of the address space
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    sb.push_back(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);

    // branch and jr selects with zero-wait fetch
    pcsource = 2'b01; bpc = 32'h200;
    sb.push_back(32'h0);
    step();
    chk("bpc_pc", pc, 32'h200);
    pcsource = 2'b10; rpc = 32'h300;
    sb.push_back(32'h200);
    step();
    chk("rpc_pc", pc, 32'h300);
    pcsource = 2'b00;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the decode-stage control unit.
- Holds the PC and selects the next PC from the decode stage's pcsource and targets.
- Fetches from a variable-latency instruction memory using a req/ack handshake and presents dinst (op = dinst[31:26], func = dinst[5:0]) and dpc4 to decode.
- Honours the hazard unit's stall and the EX-stage flush/redirect.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
wpcir  in  1  1 = IF/ID may advance; 0 = hazard stall, hold IF/ID.
pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 rpc (jr), 11 jpc (j/jal).
bpc  in  32  branch target.
rpc  in  32  register target (jr).
jpc  in  32  jump target.
flush  in  1  EX redirect: kill IF/ID and the fetch, continue at flush_pc.
flush_pc  in  32  redirect address.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address; equals pc.
imem_rdata  in  32  instruction word; valid when imem_ack=1.
imem_ack  in  1  completes the request on the edge where imem_req&imem_ack.
pc  out  32  address of the current fetch.
dpc4  out  32  IF/ID: fetched pc+4.
dinst  out  32  IF/ID: instruction to decode.
dvalid  out  1  IF/ID holds a real instruction.

Behaviour:
Reset values:
- pc = PC_RESET, dinst = NOP_INST, dpc4 = 0, dvalid = 0.
- state = S_REQ, tgt_v = 0, hold buffer = 0.
- imem_req = 1 in the first cycle after reset deasserts.

Handshake:
- imem_req and imem_addr stay stable from assertion until the ack edge.
- A request is never withdrawn; ack may arrive in the same cycle as req (zero wait).

Next-PC computation:
- npc = tgt_v ? tgt : mux(pcsource, pc+4, bpc, rpc, jpc).
- All additions are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Target latch:
- When IF/ID advances (wpcir=1) without a fetch completing, while dvalid=1 and pcsource!=00, latch tgt <= selected target and tgt_v <= 1. This keeps the jump's redirect after the jump leaves decode.
- tgt_v clears when pc <= npc is taken.
- Delay-slot semantics: the instruction fetched while a jump is in decode is kept.

States:
S_REQ (imem_req=1):
- flush (highest priority):
  - IF/ID <= bubble (dinst = NOP_INST, dvalid = 0).
  - If ack this cycle: pc <= flush_pc and tgt_v <= 0.
  - Otherwise: tgt <= flush_pc, tgt_v <= 1, go to S_DRAIN.
- ack & wpcir: dinst <= imem_rdata, dpc4 <= pc+4, dvalid <= 1, pc <= npc. Stay in S_REQ.
- ack & ~wpcir: buf <= imem_rdata, go to S_HOLD. pc and IF/ID are unchanged.
- ~ack & wpcir: IF/ID <= bubble.
- ~ack & ~wpcir: IF/ID holds.

S_HOLD (imem_req=0):
- flush: bubble, pc <= flush_pc, tgt_v <= 0, go to S_REQ.
- wpcir: dinst <= buf, dpc4 <= pc+4, dvalid <= 1, pc <= npc, go to S_REQ.
- Otherwise hold.

S_DRAIN (imem_req=1, old address):
- Wait for ack and discard the data.
- On ack: pc <= tgt, tgt_v <= 0, go to S_REQ.
- IF/ID stays a bubble throughout.
- A second flush updates tgt (latest flush wins).

Other rules:
- wpcir is ignored while IF/ID would be overwritten by a flush.
- Asserting reset at any point immediately forces all reset values, including mid-request. The memory must tolerate an abandoned request.

Test Plan:
- Zero-wait streaming: ack held 1, words A0..A3 at 0,4,8,C -> dinst = A0..A3 on consecutive cycles; dpc4 = 4,8,C,10; pc = 4,8,C,10.
- Wait states: ack delayed 3 cycles per fetch, wpcir=1 -> 3 bubble cycles (dvalid=0, dinst=0) before each instruction; imem_addr stable during the wait.
- Stall with buffer: ack at pc=8 while wpcir=0 for 2 cycles -> S_HOLD with imem_req=0, IF/ID unchanged; on release dinst = word@8, pc = C.
- Jump with slow fetch: j in IF/ID, pcsource=11, jpc=0x100, delay-slot fetch acks 2 cycles later while wpcir=1 -> delay slot delivered, then pc = 0x100 (via tgt).
- Flush mid-request: flush with flush_pc=0x40 during a fetch to 0x20 that acks 2 cycles later -> data discarded, dvalid=0 throughout, next imem_addr = 0x40.
- Reset mid-operation and wrap: reset during S_HOLD -> pc = 0, dvalid = 0, S_REQ. Separately, fetch at 0xFFFF_FFFC -> dpc4 = 0, pc = 0.
